// File: rtl/core_pkg.sv
// Shared core types: the ROB entry payload seen on the commit interface and the commit FSM states.
package core_pkg;

    localparam int PC_W = 64;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] npc;
        logic            has_except;
        logic [3:0]      except_code;
        logic            mispred;
        logic            has_rd;
        logic [4:0]      lrd;
        logic [6:0]      prd;
    } rob_entry_t;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_FLUSH     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_REDIRECT  = 2'd3
    } commit_state_e;

endpackage

// File: rtl/commit_prefix_sel.sv
// Finds the first valid slot carrying an exception or mispredict, the retire mask up to it,
// and the redirect target/cause for that slot.
module commit_prefix_sel
    import core_pkg::*;
#(
    parameter  int COMMIT_WID = 4,
    localparam int K_W        = $clog2(COMMIT_WID + 1)
) (
    input  logic [COMMIT_WID-1:0]             vld,
    input  rob_entry_t [COMMIT_WID-1:0]       data,
    output logic [K_W-1:0]                    k,
    output logic [COMMIT_WID-1:0]             retire,
    output logic                              evt_except,
    output logic [PC_W-1:0]                   evt_pc,
    output logic [3:0]                        evt_code
);

    logic found;

    always_comb begin
        k          = K_W'(COMMIT_WID);
        retire     = '0;
        evt_except = 1'b0;
        evt_pc     = '0;
        evt_code   = '0;
        found      = 1'b0;
        for (int i = 0; i < COMMIT_WID; i++) begin
            if (!found && vld[i]) begin
                // An exception wins over a mispredict in the same slot and is never retired.
                if (data[i].has_except) begin
                    found      = 1'b1;
                    k          = K_W'(i);
                    evt_except = 1'b1;
                    evt_pc     = data[i].pc;
                    evt_code   = data[i].except_code;
                end else if (data[i].mispred) begin
                    found      = 1'b1;
                    k          = K_W'(i);
                    retire[i]  = 1'b1;
                    evt_pc     = data[i].npc;
                end else begin
                    retire[i]  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rob_commit.sv
// Commit stage: retires the clean in-order prefix of the ROB's will-clear slots and sequences
// squash -> wait for flush -> redirect when an exception or mispredict reaches commit.
module rob_commit
    import core_pkg::*;
#(
    parameter  int COMMIT_WID = 4,
    parameter  int ROB_DEPTH  = 30,
    localparam int IDX_W      = $clog2(ROB_DEPTH),
    localparam int K_W        = $clog2(COMMIT_WID + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [COMMIT_WID-1:0]             i_willClear_vld,
    input  logic [COMMIT_WID-1:0][IDX_W-1:0]  i_willClear_idx,
    input  rob_entry_t [COMMIT_WID-1:0]       i_willClear_data,
    output logic                              o_stall,
    output logic [COMMIT_WID-1:0]             o_commit_vld,
    output logic [COMMIT_WID-1:0][IDX_W-1:0]  o_commit_idx,
    output logic [COMMIT_WID-1:0]             o_commit_has_rd,
    output logic [COMMIT_WID-1:0][4:0]        o_commit_lrd,
    output logic [COMMIT_WID-1:0][6:0]        o_commit_prd,
    output logic                              o_squash,
    input  logic                              i_squash_done,
    output logic                              o_redirect_vld,
    output logic [PC_W-1:0]                   o_redirect_pc,
    output logic                              o_redirect_except,
    output logic [3:0]                        o_except_code,
    output logic [63:0]                       o_retired_cnt,
    output logic [1:0]                        dbg_state
);

    // Handshake: the ROB presents will-clear slots only while o_stall is low; o_commit_vld,
    // o_squash and o_redirect_vld are single-cycle valid strobes with no back-pressure.

    localparam logic [K_W-1:0] K_NONE = K_W'(COMMIT_WID);

    commit_state_e             state_q, state_d;
    logic [K_W-1:0]            evt_k;
    logic [COMMIT_WID-1:0]     sel_retire, retire, vld_inc;
    logic                      evt_except, evt_take, in_run;
    logic [PC_W-1:0]           evt_pc;
    logic [3:0]                evt_code;
    logic [63:0]               ret_cnt;

    commit_prefix_sel #(.COMMIT_WID(COMMIT_WID)) u_sel (
        .vld        (i_willClear_vld),
        .data       (i_willClear_data),
        .k          (evt_k),
        .retire     (sel_retire),
        .evt_except (evt_except),
        .evt_pc     (evt_pc),
        .evt_code   (evt_code)
    );

    assign in_run    = (state_q == ST_RUN);
    assign retire    = in_run ? sel_retire : '0;
    assign evt_take  = in_run && (evt_k != K_NONE);
    assign o_squash       = (state_q == ST_FLUSH);
    assign o_redirect_vld = (state_q == ST_REDIRECT);
    assign dbg_state      = state_q;

    always_comb begin
        ret_cnt = '0;
        for (int i = 0; i < COMMIT_WID; i++) begin
            ret_cnt = ret_cnt + 64'(retire[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:       if (evt_take) state_d = ST_FLUSH;
            ST_FLUSH:     state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (i_squash_done) state_d = ST_REDIRECT;
            ST_REDIRECT:  state_d = ST_RUN;
            default:      state_d = ST_RUN;
        endcase
    end

    // o_stall comes from a flop fed by next-state so it never has a combinational input path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= ST_RUN;
            o_stall           <= 1'b0;
            o_commit_vld      <= '0;
            o_commit_idx      <= '0;
            o_commit_has_rd   <= '0;
            o_commit_lrd      <= '0;
            o_commit_prd      <= '0;
            o_retired_cnt     <= '0;
            o_redirect_pc     <= '0;
            o_redirect_except <= 1'b0;
            o_except_code     <= '0;
        end else begin
            state_q       <= state_d;
            o_stall       <= (state_d != ST_RUN);
            o_commit_vld  <= retire;
            o_retired_cnt <= o_retired_cnt + ret_cnt;
            for (int i = 0; i < COMMIT_WID; i++) begin
                o_commit_idx[i]    <= retire[i] ? i_willClear_idx[i] : '0;
                o_commit_has_rd[i] <= retire[i] & i_willClear_data[i].has_rd;
                o_commit_lrd[i]    <= retire[i] ? i_willClear_data[i].lrd : '0;
                o_commit_prd[i]    <= retire[i] ? i_willClear_data[i].prd : '0;
            end
            if (evt_take) begin
                o_redirect_pc     <= evt_pc;
                o_redirect_except <= evt_except;
                if (evt_except) o_except_code <= evt_code;
            end
        end
    end

    assign vld_inc = i_willClear_vld + COMMIT_WID'(1);

    a_vld_prefix: assert property (@(posedge clk) disable iff (!rst)
        (vld_inc & i_willClear_vld) == '0);

    a_idle_when_stalled: assert property (@(posedge clk) disable iff (!rst)
        !in_run |-> (i_willClear_vld == '0));

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: drivers push expected commits/redirects, a negedge monitor pops and compares.
module tb_rob_commit;
  import core_pkg::*;

  localparam int CW   = 4;
  localparam int IW   = 5;
  localparam int CE_W = CW + CW*IW + CW + CW*5 + CW*7 + 64;
  localparam int RE_W = PC_W + 1 + 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0]          wc_vld;
  logic [CW-1:0][IW-1:0]  wc_idx;
  rob_entry_t [CW-1:0]    wc_data;
  logic                   squash_done;
  logic                   o_stall, o_squash, o_redirect_vld, o_redirect_except;
  logic [CW-1:0]          o_commit_vld, o_commit_has_rd;
  logic [CW-1:0][IW-1:0]  o_commit_idx;
  logic [CW-1:0][4:0]     o_commit_lrd;
  logic [CW-1:0][6:0]     o_commit_prd;
  logic [PC_W-1:0]        o_redirect_pc;
  logic [3:0]             o_except_code;
  logic [63:0]            o_retired_cnt;
  logic [1:0]             dbg_state;

  rob_commit #(.COMMIT_WID(CW), .ROB_DEPTH(30)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_willClear_vld   (wc_vld),
    .i_willClear_idx   (wc_idx),
    .i_willClear_data  (wc_data),
    .o_stall           (o_stall),
    .o_commit_vld      (o_commit_vld),
    .o_commit_idx      (o_commit_idx),
    .o_commit_has_rd   (o_commit_has_rd),
    .o_commit_lrd      (o_commit_lrd),
    .o_commit_prd      (o_commit_prd),
    .o_squash          (o_squash),
    .i_squash_done     (squash_done),
    .o_redirect_vld    (o_redirect_vld),
    .o_redirect_pc     (o_redirect_pc),
    .o_redirect_except (o_redirect_except),
    .o_except_code     (o_except_code),
    .o_retired_cnt     (o_retired_cnt),
    .dbg_state         (dbg_state)
  );

  int total = 0;
  int bad = 0;
  int squash_seen = 0;
  int squash_exp = 0;
  logic [CE_W-1:0] exp_commit_q[$];
  logic [RE_W-1:0] exp_redir_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic clear_slots();
    wc_vld  = '0;
    wc_idx  = '0;
    wc_data = '0;
  endtask

  task automatic set_slot(input int s, input logic [IW-1:0] idx, input logic [63:0] pc,
                          input logic [63:0] npc, input logic exc, input logic [3:0] code,
                          input logic mis, input logic hrd, input logic [4:0] lrd,
                          input logic [6:0] prd);
    rob_entry_t e;
    e.pc = pc; e.npc = npc; e.has_except = exc; e.except_code = code;
    e.mispred = mis; e.has_rd = hrd; e.lrd = lrd; e.prd = prd;
    wc_idx[s]  = idx;
    wc_data[s] = e;
  endtask

  task automatic push_commit(input logic [CW-1:0] mask, input logic [63:0] cnt);
    logic [CW-1:0][IW-1:0] ei;
    logic [CW-1:0]         eh;
    logic [CW-1:0][4:0]    el;
    logic [CW-1:0][6:0]    ep;
    for (int i = 0; i < CW; i++) begin
      ei[i] = mask[i] ? wc_idx[i] : '0;
      eh[i] = mask[i] & wc_data[i].has_rd;
      el[i] = mask[i] ? wc_data[i].lrd : '0;
      ep[i] = mask[i] ? wc_data[i].prd : '0;
    end
    exp_commit_q.push_back({mask, ei, eh, el, ep, cnt});
  endtask

  task automatic push_redir(input logic [63:0] pc, input logic exc, input logic [3:0] code);
    exp_redir_q.push_back({pc, exc, code});
    squash_exp++;
  endtask

  task automatic issue(input logic [CW-1:0] mask);
    wc_vld = mask;
    @(posedge clk); #1;
    clear_slots();
  endtask

  task automatic wait_squash();
    int n;
    n = 0;
    while (!o_squash && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (!o_squash) begin
      bad++;
      $display("FAIL squash_timeout: got none within %0d cycles want pulse", n);
    end
    check("stall_in_flush", o_stall, 1);
  endtask

  task automatic complete_event(input int delay);
    repeat (delay) begin @(posedge clk); #1; end
    check("state_wait_done", dbg_state, ST_WAIT_DONE);
    check("stall_in_wait", o_stall, 1);
    squash_done = 1'b1;
    @(posedge clk); #1;
    squash_done = 1'b0;
    check("redirect_pulse", o_redirect_vld, 1);
    check("stall_in_redirect", o_stall, 1);
    @(posedge clk); #1;
    check("stall_after_redirect", o_stall, 0);
    check("state_back_run", dbg_state, ST_RUN);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      if (o_squash) squash_seen++;
      if (o_commit_vld != '0) begin
        total++;
        if (exp_commit_q.size() == 0) begin
          bad++;
          $display("FAIL commit_unexpected: got vld %b want none", o_commit_vld);
        end else begin
          logic [CE_W-1:0] e, a;
          e = exp_commit_q.pop_front();
          a = {o_commit_vld, o_commit_idx, o_commit_has_rd, o_commit_lrd, o_commit_prd, o_retired_cnt};
          if (a !== e) begin
            bad++;
            $display("FAIL commit_record: got %0h want %0h", a, e);
          end
        end
      end
      if (o_redirect_vld) begin
        total++;
        if (exp_redir_q.size() == 0) begin
          bad++;
          $display("FAIL redirect_unexpected: got pc %0h want none", o_redirect_pc);
        end else begin
          logic [RE_W-1:0] e, a;
          e = exp_redir_q.pop_front();
          a = {o_redirect_pc, o_redirect_except, o_except_code};
          if (a !== e) begin
            bad++;
            $display("FAIL redirect_record: got %0h want %0h", a, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_slots();
    squash_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", o_stall, 0);
    check("rst_commit_vld", o_commit_vld, 0);
    check("rst_squash", o_squash, 0);
    check("rst_redirect", o_redirect_vld, 0);
    check("rst_cnt", o_retired_cnt, 0);
    check("rst_state", dbg_state, ST_RUN);
    rst = 1'b1;
    @(posedge clk); #1;

    // four clean slots
    for (int i = 0; i < 4; i++)
      set_slot(i, IW'(3 + i), 64'h100 + 64'(4*i), 64'h104 + 64'(4*i), 0, 0, 0, 1, 5'(i + 1), 7'(10 + i));
    push_commit(4'b1111, 64'd4);
    issue(4'b1111);
    check("clean_stall_low", o_stall, 0);

    // single clean slot without destination
    set_slot(0, 5'd9, 64'h200, 64'h204, 0, 0, 0, 0, 5'd7, 7'd20);
    push_commit(4'b0001, 64'd5);
    issue(4'b0001);

    // exception in slot 2
    set_slot(0, 5'd7,  64'h300, 64'h304, 0, 0, 0, 1, 5'd2, 7'd30);
    set_slot(1, 5'd8,  64'h304, 64'h308, 0, 0, 0, 1, 5'd3, 7'd31);
    set_slot(2, 5'd10, 64'h8000_0040, 64'h8000_0044, 1, 4'd5, 0, 1, 5'd8, 7'd32);
    set_slot(3, 5'd11, 64'h8000_0044, 64'h8000_0048, 0, 0, 0, 1, 5'd9, 7'd33);
    push_commit(4'b0011, 64'd7);
    push_redir(64'h8000_0040, 1, 4'd5);
    issue(4'b1111);
    wait_squash();
    complete_event(3);

    // mispredict in slot 1
    set_slot(0, 5'd12, 64'h0ff8, 64'h0ffc, 0, 0, 0, 1, 5'd4, 7'd40);
    set_slot(1, 5'd13, 64'h0ffc, 64'h1000, 0, 0, 1, 1, 5'd5, 7'd41);
    set_slot(2, 5'd14, 64'h1000, 64'h1004, 0, 0, 0, 1, 5'd6, 7'd42);
    push_commit(4'b0011, 64'd9);
    push_redir(64'h1000, 0, 4'd5);
    issue(4'b0111);
    wait_squash();
    complete_event(1);

    // exception and mispredict together in slot 0
    set_slot(0, 5'd15, 64'h2000, 64'h2004, 1, 4'd3, 1, 1, 5'd1, 7'd43);
    set_slot(1, 5'd16, 64'h2004, 64'h2008, 0, 0, 0, 1, 5'd2, 7'd44);
    push_redir(64'h2000, 1, 4'd3);
    issue(4'b0011);
    wait_squash();
    complete_event(2);
    check("cnt_after_slot0_exc", o_retired_cnt, 9);

    // squash_done during FLUSH only must be ignored
    set_slot(0, 5'd16, 64'h2ffc, 64'h3000, 0, 0, 1, 1, 5'd6, 7'd50);
    push_commit(4'b0001, 64'd10);
    push_redir(64'h3000, 0, 4'd3);
    issue(4'b0001);
    wait_squash();
    squash_done = 1'b1;
    @(posedge clk); #1;
    squash_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("early_done_ignored", dbg_state, ST_WAIT_DONE);
      check("no_early_redirect", o_redirect_vld, 0);
      @(posedge clk); #1;
    end
    complete_event(0);

    // reset asserted in WAIT_DONE
    set_slot(0, 5'd17, 64'h3ffc, 64'h4000, 0, 0, 0, 0, 5'd3, 7'd60);
    set_slot(1, 5'd18, 64'h4000, 64'h4004, 1, 4'd9, 0, 1, 5'd4, 7'd61);
    push_commit(4'b0001, 64'd11);
    squash_exp++;
    issue(4'b0011);
    wait_squash();
    @(posedge clk); #1;
    check("pre_reset_wait", dbg_state, ST_WAIT_DONE);
    rst = 1'b0;
    #1;
    check("mid_rst_stall", o_stall, 0);
    check("mid_rst_state", dbg_state, ST_RUN);
    check("mid_rst_cnt", o_retired_cnt, 0);
    check("mid_rst_redirect_pc", o_redirect_pc, 0);
    check("mid_rst_code", o_except_code, 0);
    check("mid_rst_commit", o_commit_vld, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("post_rst_state", dbg_state, ST_RUN);
    check("post_rst_stall", o_stall, 0);
    check("post_rst_redirect", o_redirect_vld, 0);

    @(negedge clk);
    check("commit_q_drained", 32'(exp_commit_q.size()), 0);
    check("redir_q_drained", 32'(exp_redir_q.size()), 0);
    check("squash_pulses", 32'(squash_seen), 32'(squash_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Consumer end of the reorder buffer's commit interface. Samples the ROB's will-clear slots each cycle and retires the valid in-order prefix to the rename commit table.
- Detects exceptions and branch mispredicts among those slots, drives the ROB stall input, and sequences squash then redirect.
- Sits between the ROB, the rename unit and the frontend redirect path.

Parameters:
- COMMIT_WID, 4, number of will-clear/commit slots per cycle.
- ROB_DEPTH, 30, ROB entries; index width is $clog2(ROB_DEPTH).
- PC_W, 64, program counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- i_willClear_vld  in  COMMIT_WID  ROB slots clearing this cycle; must be a contiguous prefix starting at slot 0.
- i_willClear_idx  in  COMMIT_WID x $clog2(ROB_DEPTH)  ROB index per slot.
- i_willClear_data  in  COMMIT_WID x rob_entry_t  entry payload per slot.
- o_stall  out  1  to ROB i_stall; registered; high in every state except RUN.
- o_commit_vld  out  COMMIT_WID  retired slots, prefix form.
- o_commit_idx  out  COMMIT_WID x $clog2(ROB_DEPTH)  ROB index of each retired slot.
- o_commit_has_rd / o_commit_lrd / o_commit_prd  out  COMMIT_WID x (1/5/7)  destination update for the rename commit table.
- o_squash  out  1  one-cycle pulse: flush the backend.
- i_squash_done  in  1  backend flush complete.
- o_redirect_vld  out  1  one-cycle frontend redirect.
- o_redirect_pc  out  PC_W  redirect target.
- o_redirect_except  out  1  redirect cause is an exception.
- o_except_code  out  4  latched exception code.
- o_retired_cnt  out  64  total retired instruction count.

Behaviour:
- Reset: all outputs 0, state RUN, capture registers cleared. Reset asserted mid-FLUSH or mid-REDIRECT returns to RUN with no pulse emitted.
- States: RUN, FLUSH, WAIT_DONE, REDIRECT.
- RUN, per cycle:
  - k = lowest valid slot with has_except or mispred; k = COMMIT_WID if none.
  - Retire mask:
    - slots < k with vld;
    - plus slot k if it is a mispred without has_except.
  - Slots beyond the retire mask are discarded. The ROB has already cleared them, and the squash covers them.
  - Retire mask and payload appear on o_commit_* the next cycle (1-cycle latency).
  - o_retired_cnt += popcount(retire mask), modulo 2^64.
- Event at k:
  - Exception takes priority over mispred in the same slot.
  - Latch: exception -> target pc = entry pc, o_except_code = except_code, cause bit = 1; mispred -> target = npc, cause bit = 0.
  - Next state FLUSH.
- FLUSH, 1 cycle: o_stall = 1, o_squash = 1. Next state WAIT_DONE.
- WAIT_DONE: o_stall = 1. Waits for i_squash_done, sampled from the cycle after the o_squash pulse; i_squash_done asserted in the same cycle as o_squash is ignored. Next state REDIRECT.
- REDIRECT, 1 cycle:
  - o_redirect_vld = 1 with latched pc and cause; o_stall stays 1.
  - Next state RUN; o_stall deasserts the following cycle.
- Non-RUN states: will-clear inputs are ignored. The ROB is stalled, so they must all be 0 (assertion).
- Non-prefix i_willClear_vld is an assertion failure.
- o_stall never depends combinationally on any input, which avoids a loop with the ROB's can_clear chain.

Decomposition:
- Shared package core_pkg:
  - rob_entry_t {pc[PC_W], npc[PC_W], has_except, except_code[4], mispred, has_rd, lrd[5], prd[7]};
  - commit_state_e enum.
- One sub-module: commit_prefix_sel. Combinational; takes the vld and event bits and returns k, the retire mask and the event-slot payload mux.

Test Plan:
- Four valid clean entries, idx 3..6, has_rd set -> next cycle o_commit_vld = 4'b1111, idx 3..6, o_retired_cnt = 4, o_stall stays 0.
- Slot 2 has_except, code 5, pc 0x8000_0040 -> commit 4'b0011; FLUSH squash pulse; i_squash_done after 3 cycles; redirect_vld with pc 0x8000_0040, except = 1, code 5; o_stall low in the cycle after REDIRECT.
- Slot 1 mispred, npc 0x1000 -> commit 4'b0011, slot 2 discarded; squash, then redirect pc 0x1000 with except = 0.
- Slot 0 with both has_except and mispred -> commit 4'b0000; redirect to slot 0 pc with except = 1.
- i_squash_done held high during the FLUSH cycle only -> stays in WAIT_DONE until a later i_squash_done pulse.
- rst dropped low during WAIT_DONE -> all outputs 0 immediately; after release, state RUN with no redirect emitted.
